adc_pwm_ctrl: RTL and testbench

Parametrised successor to the single-channel ADC-to-PWM test top. It drives a serial ADC (ADCS7476-style: nCS, SCLK, SDATA), extracts an N-bit level from each frame, and checks the frame's leading zeros. It generates a glitch-free fixed-frequency PWM whose duty comes from a selectable mode, and shows the level on active-low LEDs. It sits at the board top between the ADC pins and the heater/fan driver.

---
 rtl/adc_pwm_pkg.sv | 19 +
 rtl/adc_pwm_ctrl_pwm_gen.sv | 39 +++
 rtl/adc_pwm_ctrl.sv | 147 ++++++++++++++
 tb/tb_adc_pwm_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pwm_pkg.sv
// Shared constants and types for the ADC-to-PWM controller.
// Mode encodings, ADC frame geometry and sequencer states.
package adc_pwm_pkg;

    localparam logic [1:0] MODE_DIRECT = 2'b00;
    localparam logic [1:0] MODE_INV    = 2'b01;
    localparam logic [1:0] MODE_MANUAL = 2'b10;
    localparam logic [1:0] MODE_OFF    = 2'b11;

    localparam int FRAME_BITS = 16;
    localparam int LEAD_ZEROS = 4;

    typedef enum logic [1:0] {
        QUIET,
        CONV,
        DONE
    } state_t;

endpackage

// File: rtl/adc_pwm_ctrl_pwm_gen.sv
// Fixed-period PWM generator with a duty latch that only
// reloads at the period boundary, so duty changes never produce runts.
module pwm_gen #(
    parameter int LEVEL_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] duty,
    output logic               pwm,
    output logic               period_start
);

    localparam logic [LEVEL_W-1:0] MAX = '1;

    logic [LEVEL_W-1:0] r_cnt;
    logic [LEVEL_W-1:0] r_duty;
    logic [LEVEL_W-1:0] w_cnt_nxt;
    logic [LEVEL_W-1:0] w_duty_nxt;
    logic               w_wrap;

    assign w_wrap     = (r_cnt == MAX - LEVEL_W'(1));
    assign w_cnt_nxt  = w_wrap ? '0 : r_cnt + LEVEL_W'(1);
    assign w_duty_nxt = w_wrap ? duty : r_duty;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt        <= '0;
            r_duty       <= '0;
            pwm          <= 1'b0;
            period_start <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_duty       <= w_duty_nxt;
            pwm          <= (w_cnt_nxt < w_duty_nxt);
            period_start <= w_wrap;
        end
    end

endmodule

// File: rtl/adc_pwm_ctrl.sv
// Serial ADC sequencer feeding a level register, LED mirror and
// mode-selected PWM duty for the heater/fan driver.
module adc_pwm_ctrl
    import adc_pwm_pkg::*;
#(
    parameter int LEVEL_W   = 8,
    parameter int ADC_BITS  = 12,
    parameter int CLK_DIV   = 2,
    parameter int QUIET_PER = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [LEVEL_W-1:0] manual_level,
    input  logic               SDATA,
    output logic               sclk,
    output logic               nCS,
    output logic [LEVEL_W-1:0] level,
    output logic               sample_valid,
    output logic               frame_err,
    output logic               pwm,
    output logic [LEVEL_W-1:0] led
);

    localparam int QUIET_CLKS = QUIET_PER * 2 * CLK_DIV;
    localparam int TMR_W      = $clog2(QUIET_CLKS + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS);
    localparam logic [LEVEL_W-1:0] MAX = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TMR_W-1:0]      r_tmr;
    logic [TMR_W-1:0]      w_tmr_nxt;
    logic [BIT_W-1:0]      r_bit;
    logic [BIT_W-1:0]      w_bit_nxt;
    logic                  r_half;
    logic                  w_half_nxt;
    logic                  w_half_end;
    logic                  w_shift;
    logic                  w_lead_ok;
    logic                  w_eval;
    logic [FRAME_BITS-1:0] r_shift;
    logic [LEVEL_W-1:0]    w_sample;
    logic [LEVEL_W-1:0]    w_duty_req;
    logic                  w_unused_period_start;

    assign w_half_end = (r_tmr == TMR_W'(CLK_DIV - 1));
    assign w_shift    = (r_state == CONV) && !r_half && w_half_end;
    assign w_lead_ok  = (r_shift[FRAME_BITS-1 -: LEAD_ZEROS] == '0);
    assign w_eval     = (r_state == DONE);
    assign w_sample   = r_shift[ADC_BITS-1 -: LEVEL_W];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= QUIET;
            r_tmr   <= '0;
            r_bit   <= '0;
            r_half  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_bit   <= w_bit_nxt;
            r_half  <= w_half_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr + TMR_W'(1);
        w_bit_nxt   = r_bit;
        w_half_nxt  = r_half;
        case (r_state)
            QUIET: begin
                if (r_tmr == TMR_W'(QUIET_CLKS - 1)) begin
                    w_state_nxt = CONV;
                    w_tmr_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_half_nxt  = 1'b0;
                end
            end
            CONV: begin
                if (w_half_end) begin
                    w_tmr_nxt  = '0;
                    w_half_nxt = ~r_half;
                    if (r_half) begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                        if (r_bit == BIT_W'(FRAME_BITS - 1))
                            w_state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                w_state_nxt = QUIET;
                w_tmr_nxt   = '0;
            end
            default: begin
                w_state_nxt = QUIET;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    // Pin levels are registered from the next state so they align with it.
    always_ff @(posedge clock) begin
        if (reset) begin
            nCS          <= 1'b1;
            sclk         <= 1'b1;
            r_shift      <= '0;
            level        <= '0;
            led          <= '1;
            sample_valid <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            nCS          <= (w_state_nxt != CONV);
            sclk         <= (w_state_nxt != CONV) | w_half_nxt;
            sample_valid <= w_eval && w_lead_ok;
            frame_err    <= w_eval && !w_lead_ok;
            if (w_shift)
                r_shift <= {r_shift[FRAME_BITS-2:0], SDATA};
            if (w_eval && w_lead_ok) begin
                level <= w_sample;
                led   <= ~w_sample;
            end
        end
    end

    always_comb begin
        w_duty_req = '0;
        case (mode)
            MODE_DIRECT: w_duty_req = level;
            MODE_INV:    w_duty_req = MAX - level;
            MODE_MANUAL: w_duty_req = manual_level;
            default:     w_duty_req = '0;
        endcase
    end

    pwm_gen #(
        .LEVEL_W(LEVEL_W)
    ) u_pwm (
        .clock       (clock),
        .reset       (reset),
        .duty        (w_duty_req),
        .pwm         (pwm),
        .period_start(w_unused_period_start)
    );

endmodule

// File: tb/tb_adc_pwm_ctrl.sv
// Directed bench for adc_pwm_ctrl with a behavioural ADCS7476 model.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_adc_pwm_ctrl;
    import adc_pwm_pkg::*;

    localparam int LW = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = MODE_DIRECT;
    logic [LW-1:0] manual_level = '0;
    logic          SDATA;
    logic          sclk;
    logic          nCS;
    logic [LW-1:0] level;
    logic          sample_valid;
    logic          frame_err;
    logic          pwm;
    logic [LW-1:0] led;

    logic [15:0] adc_word = 16'h0A5C;
    int          adc_idx = 0;
    int          rises = 0;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    adc_pwm_ctrl #(
        .LEVEL_W(LW), .ADC_BITS(12), .CLK_DIV(2), .QUIET_PER(1)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .mode        (mode),
        .manual_level(manual_level),
        .SDATA       (SDATA),
        .sclk        (sclk),
        .nCS         (nCS),
        .level       (level),
        .sample_valid(sample_valid),
        .frame_err   (frame_err),
        .pwm         (pwm),
        .led         (led)
    );

    // ADC: first bit on nCS fall, next bit after each sclk rise.
    always @(posedge sclk or posedge nCS) begin
        if (nCS)
            adc_idx <= 0;
        else
            adc_idx <= adc_idx + 1;
    end

    always @(posedge sclk)
        rises <= rises + 1;

    assign SDATA = (adc_idx < 16) ? adc_word[4'(15 - adc_idx)] : 1'b0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(negedge clock);
            if (pwm === 1'b1) h++;
        end
    endtask

    task automatic run_len(input logic val, output int n);
        n = 0;
        while (pwm === val && n < 300) begin
            n++;
            @(negedge clock);
        end
    endtask

    task automatic wait_result(output int cyc, output logic v,
                               output logic e);
        cyc = 0;
        v = 1'b0;
        e = 1'b0;
        while (!(v || e) && cyc < 400) begin
            @(negedge clock);
            cyc++;
            v = sample_valid;
            e = frame_err;
        end
        check("result_in_time", 32'(cyc < 400), 1);
    endtask

    initial begin
        int   r0, h, n, cyc, k;
        logic v, e, ok_ncs, ok_sclk, prev, found;

        repeat (3) @(negedge clock);
        check("rst_ncs", nCS, 1);
        check("rst_sclk", sclk, 1);
        check("rst_level", level, 0);
        check("rst_led", led, 8'hFF);
        check("rst_valid", sample_valid, 0);
        check("rst_err", frame_err, 0);
        check("rst_pwm", pwm, 0);

        reset = 1'b0;
        r0 = rises;
        ok_ncs = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (nCS !== 1'b1) ok_ncs = 1'b0;
        end
        check("quiet_ncs_high", ok_ncs, 1);
        ok_ncs = 1'b1;
        ok_sclk = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clock);
            if (nCS !== 1'b0) ok_ncs = 1'b0;
            if (sclk !== 1'((i >> 1) & 1)) ok_sclk = 1'b0;
        end
        check("conv_ncs_low", ok_ncs, 1);
        check("conv_sclk_pattern", ok_sclk, 1);
        @(negedge clock);
        check("done_ncs", nCS, 1);
        check("sclk_rises", rises - r0, 16);
        check("done_no_valid", sample_valid, 0);
        @(negedge clock);
        check("f1_valid", sample_valid, 1);
        check("f1_err", frame_err, 0);
        check("f1_level", level, 8'hA5);
        check("f1_led", led, 8'h5A);
        adc_word = 16'h8FFF;
        @(negedge clock);
        check("f1_valid_pulse", sample_valid, 0);

        wait_result(cyc, v, e);
        check("f2_err", e, 1);
        check("f2_no_valid", v, 0);
        check("frame_period", cyc, 68);
        check("f2_level_held", level, 8'hA5);

        repeat (256) @(negedge clock);
        count_high(255, h);
        check("pwm_direct_a5", h, 165);

        wait_result(cyc, v, e);
        adc_word = 16'h0400;
        wait_result(cyc, v, e);
        check("f3_valid", v, 1);
        check("f3_level", level, 8'h40);
        adc_word = 16'h8FFF;

        repeat (256) @(negedge clock);
        found = 1'b0;
        prev = pwm;
        k = 0;
        while (!found && k < 300) begin
            @(negedge clock);
            k++;
            if (prev === 1'b0 && pwm === 1'b1) found = 1'b1;
            prev = pwm;
        end
        check("pwm_rise_found", found, 1);
        repeat (10) @(negedge clock);
        mode = MODE_INV;
        run_len(1'b1, n);
        check("inv_switch_old_high", n + 10, 64);
        run_len(1'b0, n);
        check("inv_switch_old_low", n, 191);
        run_len(1'b1, n);
        check("inv_new_high", n, 191);

        mode = MODE_MANUAL;
        manual_level = 8'h00;
        repeat (256) @(negedge clock);
        count_high(255, h);
        check("manual_zero", h, 0);
        manual_level = 8'hFF;
        repeat (256) @(negedge clock);
        count_high(765, h);
        check("manual_full", h, 765);
        mode = MODE_OFF;
        repeat (256) @(negedge clock);
        count_high(255, h);
        check("mode_off", h, 0);

        mode = MODE_DIRECT;
        repeat (256) @(negedge clock);
        found = 1'b0;
        prev = nCS;
        k = 0;
        while (!found && k < 200) begin
            @(negedge clock);
            k++;
            if (prev === 1'b1 && nCS === 1'b0) found = 1'b1;
            prev = nCS;
        end
        check("ncs_fall_found", found, 1);
        repeat (37) @(negedge clock);
        check("bit9_low_half", sclk, 0);
        reset = 1'b1;
        adc_word = 16'h0A5C;
        @(negedge clock);
        check("mid_rst_ncs", nCS, 1);
        check("mid_rst_sclk", sclk, 1);
        check("mid_rst_level", level, 0);
        check("mid_rst_led", led, 8'hFF);
        check("mid_rst_pwm", pwm, 0);
        check("mid_rst_valid", sample_valid, 0);
        reset = 1'b0;
        wait_result(cyc, v, e);
        check("post_rst_valid", v, 1);
        check("post_rst_latency", cyc, 69);
        check("post_rst_level", level, 8'hA5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
